aq_reduce_seq: RTL and testbench
================================

// Module: aq_reduce_seq
// PURPOSE
//  Sequencer for the reduce datapath's two aq_calc_size instances: horizontal (per pixel) and vertical (per line).
//  Accepts an input pixel stream with SOF/EOL markers and tracks the x/y position.
//  Drives START/ENA and the shadowed ORG/CNV sizes to both instances.
//  Emits a delayed valid/position strobe aligned with the calc outputs MA/MB. Checks frame geometry.
// PARAMETERS
//  W  16  width of size config, shadows and x/y counters
// PORTS
//  RST_N       in   1  asynchronous active-low reset
//  CLK         in   1  single clock
//  ENABLE      in   1  arm: accept frames while 1
//  HOLD        in   1  stall input (forces S_READY=0)
//  ORG_X/ORG_Y in   W  input width/height in pixels/lines
//  CNV_X/CNV_Y in   W  output width/height
//  S_VALID     in   1  input beat valid
//  S_READY     out  1  input beat accepted when S_VALID&S_READY
//  S_SOF       in   1  first beat of frame
//  S_EOL       in   1  last beat of line
//  H_START     out  1  to horizontal aq_calc_size START
//  H_ENA       out  1  to horizontal aq_calc_size ENA
//  V_START     out  1  to vertical aq_calc_size START
//  V_ENA       out  1  to vertical aq_calc_size ENA
//  H_ORG/H_CNV out  W  shadowed ORG_X/CNV_X
//  V_ORG/V_CNV out  W  shadowed ORG_Y/CNV_Y
//  D_VALID     out  1  calc outputs valid for this beat (accept+2)
//  D_EOL/D_EOF out  1  beat is last of line / last of frame (with D_VALID)
//  BUSY        out  1  frame in progress
//  FRAME_DONE  out  1  1-cycle pulse after last beat of frame
//  ERR         out  1  sticky geometry error; cleared only when an SOF is accepted in IDLE
//  CFG_ERR     out  1  any of ORG_X/ORG_Y/CNV_X/CNV_Y == 0 at arm time
// BEHAVIOUR
//  Reset: all outputs, shadows, x/y and pipeline at 0; state IDLE.
//  acc = S_VALID & S_READY.
//  S_READY = !HOLD & ENABLE & (state IDLE|RUN). IDLE discards non-SOF beats.
//  States: IDLE, RUN, DONE.
//   IDLE->RUN: on acc & S_SOF & no zero config. Latch shadows; CFG_ERR=0; ERR=0; x=0, y=0.
//   If any config is zero: CFG_ERR=1 and the beat is dropped; stay in IDLE.
//   RUN: each acc advances x. Line end when x==H_ORG-1 or S_EOL=1.
//    At line end: x=0, y++. At line end with y==V_ORG-1: ->DONE.
//   DONE: 1 cycle, FRAME_DONE=1, S_READY=0, ->IDLE.
//  Calc strobes are registered, 1 cycle after acc. Shadows are already valid in that cycle.
//   H_ENA=1 for every RUN/SOF beat; H_START=1 when the beat has x==0.
//   V_ENA=V_START=0 otherwise.
//   V_ENA=1 when the beat has x==0; V_START=1 when the beat has x==0 and y==0.
//  D_VALID/D_EOL/D_EOF: 2-stage delay of acc/line-end/frame-end, i.e. acc+2, aligned with MA/MB.
//   D_EOF implies D_EOL.
//  Geometry errors set ERR; sequencing continues as follows:
//   S_EOL early (x<H_ORG-1): take the line end.
//   S_EOL missing at x==H_ORG-1: forced line end.
//   S_SOF in RUN: restart the frame. The beat is treated as the IDLE->RUN SOF beat with new shadows, except ERR stays 1.
//  ENABLE low mid-frame: S_READY=0 immediately; state/x/y hold. ENABLE high resumes the frame.
//  HOLD mid-frame: no acc, no strobes; pipeline keeps draining (no downstream backpressure).
//  Config inputs change freely; only shadows feed the calc instances.
//  Counters are W bits; line end always occurs before wrap because x<H_ORG.
//  Async reset mid-frame: immediate return to reset state; the partial frame is lost.
// STRUCTURE
//  Shared package/header aq_reduce_pkg: W default and state encodings (IDLE/RUN/DONE).
//  One natural sub-module: aq_reduce_seq_pos (x/y counters + line/frame-end compare).
//  The FSM, strobe registers and 2-stage delay stay in the top module.
//  Instantiated next to two aq_calc_size instances; MA/MB/VALID do not return to this block.
// TESTING
//  ORG=4x2, CNV=3x2, SOF + 8 beats with EOL at beats 4 and 8 ->
//   H_START at beats 1 and 5; V_START at beat 1 only; V_ENA at beats 1 and 5.
//   D_EOL at beats 4 and 8; D_EOF at beat 8; FRAME_DONE 1 cycle later; ERR=0.
//  Same frame with EOL at beat 3 -> ERR=1; the next line starts at beat 4 (H_START);
//   the frame ends after line 2.
//  SOF at beat 3 of the same frame -> ERR=1; H_START and V_START at that beat;
//   the frame is counted from that beat.
//  CNV_X=0 with SOF -> CFG_ERR=1; no H_ENA; stays IDLE.
//   Fixed config + SOF -> RUN and CFG_ERR=0.
//  HOLD for 5 cycles mid-line, and separately ENABLE low for 5 cycles mid-line ->
//   no strobes while S_READY=0; x resumes unchanged; D_VALID count is 8 per frame.
//  RST_N low at beat 5 -> all outputs 0 next edge; the next SOF starts cleanly.

Source files
------------

// File: rtl/aq_reduce_pkg.sv
// rtl/aq_reduce_pkg.sv - shared width default and sequencer state encoding
package aq_reduce_pkg;

  localparam int W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/aq_reduce_seq_pos.sv
// rtl/aq_reduce_seq_pos.sv - x/y beat position and line/frame-end compare
module aq_reduce_seq_pos
  import aq_reduce_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         beat,
  input  logic         restart,
  input  logic         s_eol,
  input  logic [W-1:0] org_x,
  input  logic [W-1:0] org_y,
  output logic [W-1:0] x_cur,
  output logic [W-1:0] y_cur,
  output logic         line_end,
  output logic         frame_end,
  output logic         geo_err
);

  logic [W-1:0] x_q, x_d;
  logic [W-1:0] y_q, y_d;
  logic         last_x;

  // A restarting beat is position 0,0 of the new frame regardless of the counters.
  always_comb begin
    x_cur     = restart ? '0 : x_q;
    y_cur     = restart ? '0 : y_q;
    last_x    = (x_cur == org_x - W'(1));
    line_end  = s_eol || last_x;
    frame_end = line_end && (y_cur == org_y - W'(1));
    geo_err   = (s_eol != last_x);
    x_d       = x_q;
    y_d       = y_q;
    if (beat) begin
      if (frame_end) begin
        x_d = '0;
        y_d = '0;
      end else if (line_end) begin
        x_d = '0;
        y_d = y_cur + W'(1);
      end else begin
        x_d = x_cur + W'(1);
        y_d = y_cur;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/aq_reduce_seq.sv
// rtl/aq_reduce_seq.sv - sequencer driving horizontal/vertical aq_calc_size instances
module aq_reduce_seq
  import aq_reduce_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         RST_N,
  input  logic         CLK,
  input  logic         ENABLE,
  input  logic         HOLD,
  input  logic [W-1:0] ORG_X,
  input  logic [W-1:0] ORG_Y,
  input  logic [W-1:0] CNV_X,
  input  logic [W-1:0] CNV_Y,
  input  logic         S_VALID,
  output logic         S_READY,
  input  logic         S_SOF,
  input  logic         S_EOL,
  output logic         H_START,
  output logic         H_ENA,
  output logic         V_START,
  output logic         V_ENA,
  output logic [W-1:0] H_ORG,
  output logic [W-1:0] H_CNV,
  output logic [W-1:0] V_ORG,
  output logic [W-1:0] V_CNV,
  output logic         D_VALID,
  output logic         D_EOL,
  output logic         D_EOF,
  output logic         BUSY,
  output logic         FRAME_DONE,
  output logic         ERR,
  output logic         CFG_ERR
);

  seq_state_t   state_q, state_d;
  logic [W-1:0] h_org_q, h_org_d, h_cnv_q, h_cnv_d;
  logic [W-1:0] v_org_q, v_org_d, v_cnv_q, v_cnv_d;
  logic         err_q, err_d, cfg_err_q, cfg_err_d;
  logic         h_start_q, h_start_d, h_ena_q, h_ena_d;
  logic         v_start_q, v_start_d, v_ena_q, v_ena_d;
  logic [2:0]   p1_q, p1_d, p2_q, p2_d;

  logic         acc, cfg_zero, sof_ok, cfg_bad, beat;
  logic [W-1:0] x_cur, y_cur;
  logic         line_end, frame_end, geo_err;

  aq_reduce_seq_pos #(.W(W)) u_pos (
    .clk       (CLK),
    .rst_n     (RST_N),
    .beat      (beat),
    .restart   (sof_ok),
    .s_eol     (S_EOL),
    .org_x     (sof_ok ? ORG_X : h_org_q),
    .org_y     (sof_ok ? ORG_Y : v_org_q),
    .x_cur     (x_cur),
    .y_cur     (y_cur),
    .line_end  (line_end),
    .frame_end (frame_end),
    .geo_err   (geo_err)
  );

  always_comb begin
    S_READY  = !HOLD && ENABLE && (state_q == ST_IDLE || state_q == ST_RUN);
    acc      = S_VALID && S_READY;
    cfg_zero = (ORG_X == '0) || (ORG_Y == '0) || (CNV_X == '0) || (CNV_Y == '0);
    sof_ok   = acc && S_SOF && !cfg_zero;
    cfg_bad  = acc && S_SOF && cfg_zero;
    beat     = sof_ok || (acc && !S_SOF && state_q == ST_RUN);

    state_d   = state_q;
    h_org_d   = h_org_q;
    h_cnv_d   = h_cnv_q;
    v_org_d   = v_org_q;
    v_cnv_d   = v_cnv_q;
    cfg_err_d = cfg_err_q;
    err_d     = err_q;

    if (state_q == ST_DONE) state_d = ST_IDLE;
    else if (cfg_bad)       state_d = ST_IDLE;
    else if (beat)          state_d = frame_end ? ST_DONE : ST_RUN;

    if (sof_ok) begin
      h_org_d   = ORG_X;
      h_cnv_d   = CNV_X;
      v_org_d   = ORG_Y;
      v_cnv_d   = CNV_Y;
      cfg_err_d = 1'b0;
    end else if (cfg_bad) begin
      cfg_err_d = 1'b1;
    end

    // Only a clean arm from IDLE clears ERR; an SOF landing mid-frame is itself an error.
    if (sof_ok && state_q == ST_IDLE) err_d = geo_err;
    else err_d = err_q || (beat && geo_err) || (acc && S_SOF && state_q == ST_RUN);

    h_ena_d   = beat;
    h_start_d = beat && (x_cur == '0);
    v_ena_d   = beat && (x_cur == '0);
    v_start_d = beat && (x_cur == '0) && (y_cur == '0);
    p1_d      = {beat, beat && line_end, beat && frame_end};
    p2_d      = p1_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      h_org_q   <= '0;
      h_cnv_q   <= '0;
      v_org_q   <= '0;
      v_cnv_q   <= '0;
      err_q     <= 1'b0;
      cfg_err_q <= 1'b0;
      h_start_q <= 1'b0;
      h_ena_q   <= 1'b0;
      v_start_q <= 1'b0;
      v_ena_q   <= 1'b0;
      p1_q      <= '0;
      p2_q      <= '0;
    end else begin
      state_q   <= state_d;
      h_org_q   <= h_org_d;
      h_cnv_q   <= h_cnv_d;
      v_org_q   <= v_org_d;
      v_cnv_q   <= v_cnv_d;
      err_q     <= err_d;
      cfg_err_q <= cfg_err_d;
      h_start_q <= h_start_d;
      h_ena_q   <= h_ena_d;
      v_start_q <= v_start_d;
      v_ena_q   <= v_ena_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
    end
  end

  assign H_START    = h_start_q;
  assign H_ENA      = h_ena_q;
  assign V_START    = v_start_q;
  assign V_ENA      = v_ena_q;
  assign H_ORG      = h_org_q;
  assign H_CNV      = h_cnv_q;
  assign V_ORG      = v_org_q;
  assign V_CNV      = v_cnv_q;
  assign D_VALID    = p2_q[2];
  assign D_EOL      = p2_q[1];
  assign D_EOF      = p2_q[0];
  assign BUSY       = (state_q != ST_IDLE);
  assign FRAME_DONE = (state_q == ST_DONE);
  assign ERR        = err_q;
  assign CFG_ERR    = cfg_err_q;

endmodule

// File: tb/tb_aq_reduce_seq.sv
// tb/tb_aq_reduce_seq.sv - scoreboard bench for aq_reduce_seq
module tb_aq_reduce_seq;
  localparam int W = 16;

  logic         RST_N, CLK, ENABLE, HOLD;
  logic [W-1:0] ORG_X, ORG_Y, CNV_X, CNV_Y;
  logic         S_VALID, S_READY, S_SOF, S_EOL;
  logic         H_START, H_ENA, V_START, V_ENA;
  logic [W-1:0] H_ORG, H_CNV, V_ORG, V_CNV;
  logic         D_VALID, D_EOL, D_EOF, BUSY, FRAME_DONE, ERR, CFG_ERR;

  aq_reduce_seq #(.W(W)) dut (
    .RST_N(RST_N), .CLK(CLK), .ENABLE(ENABLE), .HOLD(HOLD),
    .ORG_X(ORG_X), .ORG_Y(ORG_Y), .CNV_X(CNV_X), .CNV_Y(CNV_Y),
    .S_VALID(S_VALID), .S_READY(S_READY), .S_SOF(S_SOF), .S_EOL(S_EOL),
    .H_START(H_START), .H_ENA(H_ENA), .V_START(V_START), .V_ENA(V_ENA),
    .H_ORG(H_ORG), .H_CNV(H_CNV), .V_ORG(V_ORG), .V_CNV(V_CNV),
    .D_VALID(D_VALID), .D_EOL(D_EOL), .D_EOF(D_EOF), .BUSY(BUSY),
    .FRAME_DONE(FRAME_DONE), .ERR(ERR), .CFG_ERR(CFG_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int d_cnt    = 0;
  logic [2:0] exp_s[$];
  logic [1:0] exp_d[$];

  bit m_run = 0, m_err = 0, m_cfg_err = 0;
  int m_x = 0, m_y = 0, m_hx = 0, m_vy = 0;

  task automatic model_beat(input logic sof, input logic eol);
    bit le, fe, last;
    if (sof) begin
      if (ORG_X == 0 || ORG_Y == 0 || CNV_X == 0 || CNV_Y == 0) begin
        m_cfg_err = 1;
        if (m_run) m_err = 1;
        m_run = 0;
        return;
      end
      m_err = m_run;
      m_run = 1; m_x = 0; m_y = 0; m_hx = int'(ORG_X); m_vy = int'(ORG_Y); m_cfg_err = 0;
    end else if (!m_run) begin
      return;
    end
    last = (m_x == m_hx - 1);
    le = eol || last;
    if (eol != last) m_err = 1;
    fe = le && (m_y == m_vy - 1);
    exp_s.push_back({m_x == 0, m_x == 0 && m_y == 0, m_x == 0});
    exp_d.push_back({le, fe});
    if (le) begin m_x = 0; m_y++; end else m_x++;
    if (fe) m_run = 0;
  endtask

  task automatic monitor_loop();
    logic [2:0] es;
    logic [1:0] ed;
    forever begin
      @(negedge CLK);
      if (H_ENA) begin
        n_checks++;
        if (exp_s.size() == 0) begin
          n_fail++;
          $display("FAIL strobe_extra: H_ENA=1 observed, required no beat pending");
        end else begin
          es = exp_s.pop_front();
          if ({H_START, V_START, V_ENA} !== es) begin
            n_fail++;
            $display("FAIL strobes: {H_START,V_START,V_ENA}=%b required %b", {H_START, V_START, V_ENA}, es);
          end
        end
      end else if (H_START || V_START || V_ENA) begin
        n_checks++; n_fail++;
        $display("FAIL strobe_idle: {H_START,V_START,V_ENA}=%b with H_ENA=0, required 000", {H_START, V_START, V_ENA});
      end
      if (D_VALID) begin
        d_cnt++;
        n_checks++;
        if (exp_d.size() == 0) begin
          n_fail++;
          $display("FAIL d_extra: D_VALID=1 observed, required none pending");
        end else begin
          ed = exp_d.pop_front();
          if ({D_EOL, D_EOF} !== ed) begin
            n_fail++;
            $display("FAIL d_marks: {D_EOL,D_EOF}=%b required %b", {D_EOL, D_EOF}, ed);
          end
        end
      end
    end
  endtask

  task automatic drive_beat(input logic sof, input logic eol);
    int guard;
    guard = 0;
    S_VALID = 1'b1; S_SOF = sof; S_EOL = eol;
    #1;
    while (!S_READY && guard < 20) begin
      @(negedge CLK); #1; guard++;
    end
    if (!S_READY) begin
      n_checks++; n_fail++;
      $display("FAIL ready_timeout: S_READY=0 after %0d cycles, required 1", guard);
    end else begin
      model_beat(sof, eol);
    end
    @(negedge CLK);
    S_VALID = 1'b0; S_SOF = 1'b0; S_EOL = 1'b0;
  endtask

  task automatic drain_and_check(input string name, input int d0, input int n_exp);
    repeat (4) @(negedge CLK);
    n_checks++;
    if (d_cnt - d0 != n_exp) begin
      n_fail++; $display("FAIL %s_dcount: D_VALID beats=%0d required %0d", name, d_cnt - d0, n_exp);
    end
    n_checks++;
    if (exp_s.size() != 0 || exp_d.size() != 0) begin
      n_fail++; $display("FAIL %s_pending: strobe/d entries left %0d/%0d required 0/0", name, exp_s.size(), exp_d.size());
    end
    n_checks++;
    if (ERR !== m_err) begin
      n_fail++; $display("FAIL %s_err: ERR=%b required %b", name, ERR, m_err);
    end
  endtask

  task automatic test_reset();
    logic [75:0] outs;
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    outs = {H_START, H_ENA, V_START, V_ENA, H_ORG, H_CNV, V_ORG, V_CNV,
            D_VALID, D_EOL, D_EOF, BUSY, FRAME_DONE, ERR, CFG_ERR};
    n_checks++;
    if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h required 0", outs); end
    RST_N = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (BUSY !== 1'b0 || S_READY !== 1'b1) begin
      n_fail++; $display("FAIL reset_idle: BUSY=%b S_READY=%b required 0/1", BUSY, S_READY);
    end
  endtask

  task automatic test_basic();
    int d0;
    ORG_X = 4; ORG_Y = 2; CNV_X = 3; CNV_Y = 2;
    d0 = d_cnt;
    for (int i = 1; i <= 8; i++) drive_beat(i == 1, i == 4 || i == 8);
    n_checks++;
    if (FRAME_DONE !== 1'b1) begin n_fail++; $display("FAIL basic_frame_done: FRAME_DONE=%b required 1", FRAME_DONE); end
    n_checks++;
    if ({H_ORG, H_CNV, V_ORG, V_CNV} !== {16'd4, 16'd3, 16'd2, 16'd2}) begin
      n_fail++; $display("FAIL basic_shadows: %0d/%0d/%0d/%0d required 4/3/2/2", H_ORG, H_CNV, V_ORG, V_CNV);
    end
    @(negedge CLK);
    n_checks++;
    if (FRAME_DONE !== 1'b0 || BUSY !== 1'b0) begin
      n_fail++; $display("FAIL basic_done_pulse: FRAME_DONE=%b BUSY=%b required 0/0", FRAME_DONE, BUSY);
    end
    drain_and_check("basic", d0, 8);
    n_checks++;
    if (ERR !== 1'b0) begin n_fail++; $display("FAIL basic_err_clear: ERR=%b required 0", ERR); end
  endtask

  task automatic test_early_eol();
    int d0;
    d0 = d_cnt;
    for (int i = 1; i <= 7; i++) drive_beat(i == 1, i == 3 || i == 7);
    n_checks++;
    if (FRAME_DONE !== 1'b1) begin n_fail++; $display("FAIL early_frame_done: FRAME_DONE=%b required 1", FRAME_DONE); end
    drain_and_check("early", d0, 7);
    n_checks++;
    if (ERR !== 1'b1) begin n_fail++; $display("FAIL early_err: ERR=%b required 1", ERR); end
  endtask

  task automatic test_sof_restart();
    int d0;
    d0 = d_cnt;
    drive_beat(1'b1, 1'b0);
    drive_beat(1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) drive_beat(i == 1, i == 4 || i == 8);
    drain_and_check("restart", d0, 10);
    n_checks++;
    if (ERR !== 1'b1) begin n_fail++; $display("FAIL restart_err: ERR=%b required 1", ERR); end
  endtask

  task automatic test_cfg();
    int d0;
    d0 = d_cnt;
    CNV_X = 0;
    drive_beat(1'b1, 1'b0);
    n_checks++;
    if (CFG_ERR !== 1'b1 || BUSY !== 1'b0) begin
      n_fail++; $display("FAIL cfg_zero: CFG_ERR=%b BUSY=%b required 1/0", CFG_ERR, BUSY);
    end
    drain_and_check("cfg_zero", d0, 0);
    CNV_X = 3;
    d0 = d_cnt;
    drive_beat(1'b1, 1'b0);
    n_checks++;
    if (CFG_ERR !== 1'b0 || BUSY !== 1'b1 || ERR !== 1'b0) begin
      n_fail++; $display("FAIL cfg_fixed: CFG_ERR=%b BUSY=%b ERR=%b required 0/1/0", CFG_ERR, BUSY, ERR);
    end
    for (int i = 2; i <= 8; i++) drive_beat(1'b0, i == 4 || i == 8);
    drain_and_check("cfg_fixed", d0, 8);
  endtask

  task automatic test_stall(input bit use_hold);
    int d0;
    d0 = d_cnt;
    drive_beat(1'b1, 1'b0);
    drive_beat(1'b0, 1'b0);
    S_VALID = 1'b1;
    if (use_hold) HOLD = 1'b1; else ENABLE = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      n_checks++;
      if (S_READY !== 1'b0 || BUSY !== 1'b1) begin
        n_fail++; $display("FAIL stall_ready(hold=%0d,c=%0d): S_READY=%b BUSY=%b required 0/1", use_hold, c, S_READY, BUSY);
      end
      if (c > 0) begin
        n_checks++;
        if (H_ENA !== 1'b0) begin n_fail++; $display("FAIL stall_strobe(hold=%0d): H_ENA=%b required 0", use_hold, H_ENA); end
      end
    end
    HOLD = 1'b0; ENABLE = 1'b1;
    for (int i = 3; i <= 8; i++) drive_beat(1'b0, i == 4 || i == 8);
    drain_and_check(use_hold ? "hold" : "enable", d0, 8);
  endtask

  task automatic test_reset_mid();
    int d0;
    logic [75:0] outs;
    for (int i = 1; i <= 4; i++) drive_beat(i == 1, i == 4);
    #1;
    RST_N = 1'b0;
    exp_s.delete(); exp_d.delete();
    m_run = 0; m_err = 0; m_cfg_err = 0;
    #1;
    outs = {H_START, H_ENA, V_START, V_ENA, H_ORG, H_CNV, V_ORG, V_CNV,
            D_VALID, D_EOL, D_EOF, BUSY, FRAME_DONE, ERR, CFG_ERR};
    n_checks++;
    if (outs !== '0) begin n_fail++; $display("FAIL midreset_outputs: got %h required 0", outs); end
    @(negedge CLK);
    RST_N = 1'b1;
    d0 = d_cnt;
    for (int i = 1; i <= 8; i++) drive_beat(i == 1, i == 4 || i == 8);
    n_checks++;
    if (FRAME_DONE !== 1'b1) begin n_fail++; $display("FAIL midreset_frame_done: FRAME_DONE=%b required 1", FRAME_DONE); end
    drain_and_check("midreset", d0, 8);
  endtask

  initial begin
    RST_N = 1'b0; ENABLE = 1'b1; HOLD = 1'b0;
    ORG_X = 4; ORG_Y = 2; CNV_X = 3; CNV_Y = 2;
    S_VALID = 1'b0; S_SOF = 1'b0; S_EOL = 1'b0;
    fork
      monitor_loop();
    join_none
    test_reset();
    test_basic();
    test_early_eol();
    test_sof_restart();
    test_cfg();
    test_stall(1'b1);
    test_stall(1'b0);
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
